// File: rtl/fpga_cfg_loader.sv
// rtl/fpga_cfg_loader.sv - streams configuration words into one-hot fabric slots, then enables the fabric
// Optional trailing checksum word and err_sum port under FPGA_CFG_LOADER_CHECKSUM_EN.
module fpga_cfg_loader #(
  parameter int CFG_W      = 320,
  parameter int N_SLOTS    = 172,
  parameter int PRE_CYC    = 10,
  parameter int HOLD_CYC   = 1,
  parameter int SETTLE_CYC = 10
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               start,
  input  logic               cfg_valid,
  input  logic [CFG_W-1:0]   cfg_data,
  input  logic               cfg_last,
  output logic               cfg_ready,
  output logic [CFG_W-1:0]   configs_in,
  output logic [N_SLOTS-1:0] configs_en,
  output logic               ff_en,
  output logic               rdy,
  output logic               busy,
`ifdef FPGA_CFG_LOADER_CHECKSUM_EN
  output logic               err_sum,
`endif
  output logic               err_len
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_LOAD, S_HOLD, S_SETTLE, S_FFON, S_DONE
  } state_t;

  localparam int MAX_CYC = (PRE_CYC > HOLD_CYC)
                         ? ((PRE_CYC > SETTLE_CYC) ? PRE_CYC : SETTLE_CYC)
                         : ((HOLD_CYC > SETTLE_CYC) ? HOLD_CYC : SETTLE_CYC);
  localparam int TW = $clog2(MAX_CYC + 1);
  localparam int CW = $clog2(N_SLOTS + 1);
  localparam logic [TW-1:0] PRE_LAST    = TW'((PRE_CYC > 0) ? PRE_CYC - 1 : 0);
  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] CNT_FULL    = CW'(N_SLOTS);
  localparam state_t        START_TO    = (PRE_CYC == 0) ? S_LOAD : S_PRE;
`ifdef FPGA_CFG_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  state_t          state, state_nxt;
  logic [TW-1:0]   tmr;
  logic [CW-1:0]   word_cnt;
  logic            last_q;
  logic [1:0]      rst_sync;
  logic            rst_n_i;
  logic            start_ok, handshake, hold_done, terminate, load_entry;
  logic            sum_phase, stuck;

  // Assertion is immediate; release is re-timed to clock so all flops leave reset together.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_i = rst_sync[1];

  assign start_ok   = start & ((state == S_IDLE) | (state == S_DONE) | stuck);
  assign handshake  = cfg_valid & cfg_ready;
  assign hold_done  = (state == S_HOLD) && (tmr == HOLD_LAST);
  assign terminate  = hold_done && (last_q || (word_cnt == CNT_FULL));
  assign load_entry = (state_nxt == S_LOAD) && ((state == S_PRE) || start_ok);

  always_ff @(posedge clock or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= S_IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= (state_nxt != state) ? '0 : tmr + TW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start_ok) state_nxt = START_TO;
      S_PRE:          if (tmr == PRE_LAST) state_nxt = S_LOAD;
      S_LOAD:         if (handshake) state_nxt = sum_phase ? S_SETTLE : S_HOLD;
      S_HOLD:         if (hold_done) state_nxt = (terminate && !CSUM_EN) ? S_SETTLE : S_LOAD;
      S_SETTLE: begin
        if (start_ok)                              state_nxt = START_TO;
        else if (!stuck && tmr == SETTLE_LAST)     state_nxt = S_FFON;
      end
      S_FFON:         state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b0;
    busy      = 1'b0;
    cfg_ready = (state == S_LOAD);
    busy      = (state != S_IDLE) && (state != S_DONE);
  end

  always_ff @(posedge clock or negedge rst_n_i) begin
    if (!rst_n_i) begin
      configs_in <= '0;
      configs_en <= '0;
      word_cnt   <= '0;
      last_q     <= 1'b0;
      err_len    <= 1'b0;
      ff_en      <= 1'b0;
      rdy        <= 1'b0;
    end else begin
      if (start_ok) begin
        configs_en <= '0;
        word_cnt   <= '0;
        last_q     <= 1'b0;
        err_len    <= 1'b0;
        ff_en      <= 1'b0;
        rdy        <= 1'b0;
      end
      if (load_entry) begin
        configs_en <= N_SLOTS'(1);
        word_cnt   <= '0;
      end
      if (handshake && !sum_phase) begin
        configs_in <= cfg_data;
        word_cnt   <= word_cnt + CW'(1);
        last_q     <= cfg_last;
      end
      if (hold_done) begin
        if (terminate) begin
          configs_en <= '0;
          if (word_cnt != CNT_FULL) err_len <= 1'b1;
        end else begin
          configs_en <= configs_en << 1;
        end
      end
      if (state == S_FFON)              ff_en <= 1'b1;
      if (state == S_DONE && !start_ok) rdy   <= 1'b1;
    end
  end

`ifdef FPGA_CFG_LOADER_CHECKSUM_EN
  logic [CFG_W-1:0] sum_q;
  logic             sum_phase_q, err_sum_q;

  // The checksum word is taken in LOAD after termination; a mismatch parks the block in SETTLE.
  always_ff @(posedge clock or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sum_q       <= '0;
      sum_phase_q <= 1'b0;
      err_sum_q   <= 1'b0;
    end else if (start_ok) begin
      sum_q       <= '0;
      sum_phase_q <= 1'b0;
      err_sum_q   <= 1'b0;
    end else begin
      if (handshake && !sum_phase_q) sum_q <= sum_q ^ cfg_data;
      if (terminate)                 sum_phase_q <= 1'b1;
      if (handshake && sum_phase_q) begin
        sum_phase_q <= 1'b0;
        if (cfg_data != sum_q) err_sum_q <= 1'b1;
      end
    end
  end
  assign sum_phase = sum_phase_q;
  assign stuck     = err_sum_q;
  assign err_sum   = err_sum_q;
`else
  assign sum_phase = 1'b0;
  assign stuck     = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// tb/tb_fpga_cfg_loader.sv - randomized self-checking bench for fpga_cfg_loader
// Checksum scenarios run only when FPGA_CFG_LOADER_CHECKSUM_EN is defined.
module tb_fpga_cfg_loader;
  localparam int CFG_W      = 16;
  localparam int N_SLOTS    = 4;
  localparam int PRE_CYC    = 2;
  localparam int HOLD_CYC   = 3;
  localparam int SETTLE_CYC = 5;

  logic               clock = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic               cfg_valid = 1'b0;
  logic [CFG_W-1:0]   cfg_data = '0;
  logic               cfg_last = 1'b0;
  logic               cfg_ready;
  logic [CFG_W-1:0]   configs_in;
  logic [N_SLOTS-1:0] configs_en;
  logic               ff_en, rdy, busy, err_len;
`ifdef FPGA_CFG_LOADER_CHECKSUM_EN
  logic               err_sum;
  bit                 bad_sum = 1'b0;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  logic [CFG_W-1:0] words [N_SLOTS];

  fpga_cfg_loader #(
    .CFG_W(CFG_W), .N_SLOTS(N_SLOTS), .PRE_CYC(PRE_CYC),
    .HOLD_CYC(HOLD_CYC), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clock(clock), .rst(rst), .start(start), .cfg_valid(cfg_valid),
    .cfg_data(cfg_data), .cfg_last(cfg_last), .cfg_ready(cfg_ready),
    .configs_in(configs_in), .configs_en(configs_en), .ff_en(ff_en),
    .rdy(rdy), .busy(busy),
`ifdef FPGA_CFG_LOADER_CHECKSUM_EN
    .err_sum(err_sum),
`endif
    .err_len(err_len)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < N_SLOTS; i++) words[i] = CFG_W'($urandom);
  endtask

  // Drives one complete load and checks it against the slot-by-slot expectation.
  task automatic run_load(input int last_at, input int valid_pct, input bit pulse_in_load,
                          input int abort_at);
    int n_acc, guard;
    bit exp_err, hs;
    logic [N_SLOTS-1:0] exp_en;
`ifdef FPGA_CFG_LOADER_CHECKSUM_EN
    logic [CFG_W-1:0] sum;
    sum = '0;
`endif
    n_acc   = (last_at >= 0 && last_at < N_SLOTS) ? last_at + 1 : N_SLOTS;
    exp_err = (n_acc != N_SLOTS);

    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({ff_en, rdy, err_len, busy} !== 4'b0001) begin
      n_fail++;
      $display("FAIL start_clear: got ff_en/rdy/err_len/busy=%b want 0001", {ff_en, rdy, err_len, busy});
    end

    for (int c = 0; c < PRE_CYC; c++) begin
      n_cmp++;
      if (cfg_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL pre_ready: cycle %0d got %b want 0", c, cfg_ready);
      end
      cfg_valid = 1'($urandom_range(1));
      cfg_data  = CFG_W'($urandom);
      tick();
    end

    for (int k = 0; k < n_acc; k++) begin
      exp_en = '0;
      exp_en[k] = 1'b1;
      n_cmp++;
      if (configs_en !== exp_en) begin
        n_fail++;
        $display("FAIL load_en: word %0d got %b want %b", k, configs_en, exp_en);
      end
      guard = 0;
      hs = 1'b0;
      while (!hs && guard < 200) begin
        cfg_valid = ($urandom_range(99) < valid_pct);
        cfg_data  = cfg_valid ? words[k] : CFG_W'($urandom);
        cfg_last  = cfg_valid ? (k == last_at) : 1'($urandom_range(1));
        start     = pulse_in_load && (k == 1) && (guard == 0);
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL load_ready: word %0d got %b want 1", k, cfg_ready);
        end
        hs = cfg_valid;
        tick();
        guard++;
      end
      start = 1'b0;
      if (!hs) begin
        n_cmp++;
        n_fail++;
        $display("FAIL handshake_timeout: word %0d got no handshake want one", k);
        return;
      end
`ifdef FPGA_CFG_LOADER_CHECKSUM_EN
      sum ^= words[k];
`endif
      for (int h = 0; h < HOLD_CYC; h++) begin
        n_cmp++;
        if (configs_in !== words[k] || configs_en !== exp_en || cfg_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL hold: word %0d cyc %0d got in=%h en=%b rdy_in=%b want in=%h en=%b rdy_in=0",
                   k, h, configs_in, configs_en, cfg_ready, words[k], exp_en);
        end
        if (k == abort_at && h == 1) begin
          #2 rst = 1'b0;
          #1;
          n_cmp++;
          if ({configs_in, configs_en, cfg_ready, ff_en, rdy, busy, err_len} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got in=%h en=%b ready=%b ff=%b rdy=%b busy=%b err=%b want all 0",
                     configs_in, configs_en, cfg_ready, ff_en, rdy, busy, err_len);
          end
          cfg_valid = 1'b0;
          cfg_last  = 1'b0;
          tick();
          tick();
          rst = 1'b1;
          repeat (4) tick();
          return;
        end
        cfg_valid = 1'($urandom_range(1));
        cfg_data  = CFG_W'($urandom);
        cfg_last  = 1'($urandom_range(1));
        tick();
      end
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;

    n_cmp++;
    if (configs_en !== '0) begin
      n_fail++;
      $display("FAIL end_en: got %b want 0", configs_en);
    end
`ifdef FPGA_CFG_LOADER_CHECKSUM_EN
    n_cmp++;
    if (cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL csum_ready: got %b want 1", cfg_ready);
    end
    cfg_valid = 1'b1;
    cfg_data  = bad_sum ? (sum ^ CFG_W'(1)) : sum;
    tick();
    cfg_valid = 1'b0;
    n_cmp++;
    if (configs_in !== words[n_acc-1] || configs_en !== '0) begin
      n_fail++;
      $display("FAIL csum_word: got in=%h en=%b want in=%h en=0", configs_in, configs_en, words[n_acc-1]);
    end
    if (bad_sum) begin
      hs = 1'b0;
      for (int i = 0; i < 120; i++) begin
        if (ff_en !== 1'b0 || rdy !== 1'b0 || err_sum !== 1'b1) hs = 1'b1;
        tick();
      end
      n_cmp++;
      if (hs) begin
        n_fail++;
        $display("FAIL csum_bad: got ff_en=%b rdy=%b err_sum=%b want 0 0 1 for 120 cycles", ff_en, rdy, err_sum);
      end
      return;
    end
`endif
    for (int s = 0; s <= SETTLE_CYC; s++) begin
      n_cmp++;
      if (ff_en !== 1'b0 || cfg_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL settle: cyc %0d got ff_en=%b ready=%b busy=%b want 0 0 1", s, ff_en, cfg_ready, busy);
      end
      cfg_valid = 1'($urandom_range(1));
      cfg_data  = CFG_W'($urandom);
      tick();
    end
    cfg_valid = 1'b0;
    n_cmp++;
    if (ff_en !== 1'b1 || rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL ff_en_rise: got ff_en=%b rdy=%b want 1 0", ff_en, rdy);
    end
    tick();
    n_cmp++;
    if (rdy !== 1'b1 || ff_en !== 1'b1 || busy !== 1'b0 || err_len !== exp_err) begin
      n_fail++;
      $display("FAIL done: got rdy=%b ff_en=%b busy=%b err_len=%b want 1 1 0 %b", rdy, ff_en, busy, err_len, exp_err);
    end
`ifdef FPGA_CFG_LOADER_CHECKSUM_EN
    n_cmp++;
    if (err_sum !== 1'b0) begin
      n_fail++;
      $display("FAIL err_sum_good: got %b want 0", err_sum);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if ({configs_in, configs_en, cfg_ready, ff_en, rdy, busy, err_len} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got in=%h en=%b ready=%b ff=%b rdy=%b busy=%b err=%b want all 0",
               configs_in, configs_en, cfg_ready, ff_en, rdy, busy, err_len);
    end
    rst = 1'b1;
    repeat (4) tick();
    n_cmp++;
    if (busy !== 1'b0 || cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b ready=%b want 0 0", busy, cfg_ready);
    end
  endtask

  task automatic test_full_load();
    fill_random();
    run_load(-1, 100, 1'b0, -1);
  endtask

  task automatic test_early_last();
    fill_random();
    run_load(1, 100, 1'b0, -1);
  endtask

  task automatic test_random_valid();
    for (int r = 0; r < 3; r++) begin
      fill_random();
      run_load((r == 1) ? N_SLOTS - 1 : -1, 50, 1'b0, -1);
    end
  endtask

  task automatic test_reset_mid();
    fill_random();
    run_load(-1, 70, 1'b0, 2);
    fill_random();
    run_load(-1, 70, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    logic [CFG_W-1:0] held;
    fill_random();
    run_load(-1, 100, 1'b1, -1);
    held = words[N_SLOTS-1];
    for (int i = 0; i < 6; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = CFG_W'($urandom);
      tick();
    end
    cfg_valid = 1'b0;
    n_cmp++;
    if (configs_in !== held || cfg_ready !== 1'b0 || rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL done_ignores_valid: got in=%h ready=%b rdy=%b want in=%h ready=0 rdy=1",
               configs_in, cfg_ready, rdy, held);
    end
    fill_random();
    run_load(-1, 60, 1'b0, -1);
  endtask

`ifdef FPGA_CFG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    for (int i = 0; i < N_SLOTS; i++) words[i] = CFG_W'(1 << i);
    bad_sum = 1'b0;
    run_load(-1, 100, 1'b0, -1);
    bad_sum = 1'b1;
    run_load(-1, 100, 1'b0, -1);
    bad_sum = 1'b0;
    fill_random();
    run_load(-1, 80, 1'b0, -1);
  endtask
`endif

  initial begin
    test_reset();
    test_full_load();
    test_early_last();
    test_random_valid();
    test_reset_mid();
    test_back_to_back();
`ifdef FPGA_CFG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fpga_cfg_loader.md
Name: fpga_cfg_loader

Overview:
- Synthesizable bitstream loader for the `fpga` fabric; it replaces the file-driven initial-block loading in the test wrappers.
- Accepts configuration words on a valid/ready stream and presents each word on `configs_in`, with a one-hot `configs_en` selecting the target slot.
- After the last slot it waits a settle interval, then asserts `ff_en`, then `rdy`.
- Sits between a host/ROM word source and the `fpga` top; width, slot count and timing are parametrised.

Parameters:
- CFG_W, 320, configuration word width (`configs_in` width).
- N_SLOTS, 172, number of config slots (`configs_en` width).
- PRE_CYC, 10, idle cycles after `start` before the first word is accepted (≥0).
- HOLD_CYC, 1, cycles each word is held on `configs_in` with its slot enabled, before the slot advances (≥1).
- SETTLE_CYC, 10, cycles between the end of loading and `ff_en` assertion (≥1).

Ports:
- clock  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load when the block is idle or done.
- cfg_valid  in  1  source has a word.
- cfg_data  in  CFG_W  configuration word.
- cfg_last  in  1  marks the final word; qualified by the handshake.
- cfg_ready  out  1  loader accepts a word this cycle.
- configs_in  out  CFG_W  word presented to the fabric.
- configs_en  out  N_SLOTS  one-hot slot enable.
- ff_en  out  1  fabric flip-flop enable.
- rdy  out  1  configuration complete, fabric running.
- busy  out  1  load in progress (any state other than IDLE or DONE).
- err_len  out  1  sticky; word count ≠ N_SLOTS at termination.

Behaviour:
- Reset (async assert, sync deassert inside the block): state=IDLE; `configs_in`=0, `configs_en`=0, `cfg_ready`=0, `ff_en`=0, `rdy`=0, `busy`=0, `err_len`=0, word count=0.
- States and transitions:
  - IDLE: wait for `start`.
  - PRE: count PRE_CYC cycles.
  - LOAD: `cfg_ready`=1.
  - HOLD: count HOLD_CYC cycles.
  - SETTLE: count SETTLE_CYC cycles.
  - FFON: one cycle.
  - DONE.
- Sequence: IDLE --start--> PRE --(PRE_CYC done; if PRE_CYC=0, directly)--> LOAD.
- On entry to LOAD from PRE: `configs_en` = one-hot bit 0; word count = 0.
- LOAD handshake (`cfg_valid` & `cfg_ready`):
  - `configs_in` <= `cfg_data` at that edge; count++; go to HOLD.
  - `cfg_ready` drops the cycle after the handshake (at most one word per HOLD period).
- HOLD, after HOLD_CYC cycles:
  - If count==N_SLOTS or last-flag set: `configs_en` <= 0, go to SETTLE.
  - Otherwise: `configs_en` <= `configs_en`<<1, go to LOAD.
- `configs_in` holds its last value until the next handshake or reset; it is never cleared mid-load.
- Termination rules:
  - `cfg_last` on word k<N_SLOTS: early termination; `err_len`=1 at SETTLE entry.
  - Count reaching N_SLOTS without `cfg_last`: normal termination, no error; `cfg_last` on word N_SLOTS is also normal.
  - No word beyond N_SLOTS is ever accepted.
- Error handling: `err_len` is sticky until the next `start` or reset. `rdy` still asserts on error; the host checks `err_len`.
- SETTLE --SETTLE_CYC--> FFON: `ff_en`=1. Next cycle DONE: `rdy`=1. Both hold.
- Latency: the last handshake to `ff_en` takes HOLD_CYC+SETTLE_CYC+1 cycles.
- `start` while busy is ignored.
- `start` in DONE: `ff_en`, `rdy` and `err_len` clear the next cycle, then the full sequence reruns (reconfiguration).
- `cfg_valid` outside LOAD is ignored; no word is consumed.
- Reset mid-load: immediate return to reset values; the partial load is abandoned.
- `busy`=1 in PRE, LOAD, HOLD, SETTLE and FFON.

Optional Feature:
- Macro: `FPGA_CFG_LOADER_CHECKSUM_EN`.
- With the macro defined:
  - The loader keeps a running XOR of all accepted words.
  - After termination, LOAD accepts one extra checksum word (`configs_en`=0, `configs_in` unchanged).
  - If the checksum word ≠ the XOR, output `err_sum`=1 (sticky) and the block stays in SETTLE forever; neither `ff_en` nor `rdy` asserts until the next `start` or reset.
  - The `err_sum` port exists only with the macro.
- Without the macro: no checksum word and no `err_sum` port.

Test Plan:
- Default params, N_SLOTS=4 override, words A,B,C,D, valid always high -> `configs_en` steps 0001, 0010, 0100, 1000, then 0000; `configs_in` matches each word while its bit is set; `ff_en` exactly SETTLE_CYC+1 cycles after the last HOLD ends; `rdy` one cycle later; `err_len`=0.
- N_SLOTS=4, `cfg_last` on the 2nd word -> `configs_en` 0001, 0010, then 0000; `err_len`=1; `rdy`=1.
- `cfg_valid` toggled 1-0-1 randomly, HOLD_CYC=3 -> no word lost or duplicated; each word is held exactly 3 cycles; `cfg_ready` never high in HOLD.
- `rst` pulled low during the 3rd word's HOLD -> all outputs 0 asynchronously; after release, `start` reloads correctly from slot 0.
- `start` pulsed during LOAD (ignored), then again in DONE -> `rdy` and `ff_en` drop next cycle; the second load completes with `rdy`=1.
- `FPGA_CFG_LOADER_CHECKSUM_EN` defined, words 0x1, 0x2, 0x4, 0x8 with checksum 0xF -> `rdy`=1. Repeat with checksum 0xE -> `err_sum`=1, and `ff_en`/`rdy` remain 0 for ≥100 cycles.
